// File: rtl/gpu_wb_pkg.sv
// gpu_wb_pkg: shared FSM states, queued write command layout and GPU address map.
package gpu_wb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;
  typedef struct packed {
    logic [26:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [7:0]  count;
  } cmd_t;
  // Control/sprite registers live below TILE_BASE, texture memory from TEX_BASE up.
  localparam logic [26:0] CR_BASE   = 27'h0000;
  localparam logic [26:0] TILE_BASE = 27'h1000;
  localparam logic [26:0] TEX_BASE  = 27'h2000;
endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: single-clock command FIFO with occupancy, full and empty flags.
module gpu_cmd_fifo
  import gpu_wb_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        i_push,
  input  cmd_t        i_data,
  input  logic        i_pop,
  output cmd_t        o_head,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_level
);
  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;
  assign o_full  = r_level == (AW+1)'(DEPTH);
  assign o_empty = r_level == '0;
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge clk_100MHz)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop) r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end
endmodule

// File: rtl/gpu_wb_write_queue.sv
// gpu_wb_write_queue: buffered Wishbone write master pacing CPU writes and fills into the GPU slave.
module gpu_wb_write_queue
  import gpu_wb_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_STEP = 1,
  parameter int MIN_HOLD  = 2,
  parameter int TIMEOUT   = 255,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int HW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk_100MHz,
  input  logic          reset_n,
  input  logic          i_push_valid,
  output logic          o_push_ready,
  input  logic [26:0]   i_push_addr,
  input  logic [31:0]   i_push_data,
  input  logic [3:0]    i_push_sel,
  input  logic [7:0]    i_push_count,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic [26:0]   wb_adr_o,
  output logic [31:0]   wb_dat_o,
  input  logic          wb_ack_i,
  output logic          o_busy,
  output logic [LW-1:0] o_level,
  output logic          o_timeout,
  input  logic          i_clr_timeout
);
  state_t        r_state;
  cmd_t          w_push_cmd;
  cmd_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_done;
  logic          w_abort;
  logic [26:0]   r_addr;
  logic [31:0]   r_data;
  logic [3:0]    r_sel;
  logic [7:0]    r_rem;
  logic [HW-1:0] r_hold;
  logic          r_timeout;
  assign w_push_cmd = '{addr: i_push_addr, data: i_push_data, sel: i_push_sel, count: i_push_count};
  // A new command is taken from IDLE, or straight from GAP once the current one is finished.
  assign w_pop   = !w_empty && (r_state == S_IDLE || (r_state == S_GAP && !(|r_rem)));
  assign w_done  = wb_ack_i && r_hold >= HW'(MIN_HOLD);
  assign w_abort = !w_done && r_hold >= HW'(TIMEOUT);
  gpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_100MHz(clk_100MHz),
    .reset_n   (reset_n),
    .i_push    (i_push_valid),
    .i_data    (w_push_cmd),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (o_level)
  );
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_data    <= '0;
      r_sel     <= '0;
      r_rem     <= '0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == S_WRITE && w_abort) || (r_timeout && !i_clr_timeout);
      if (w_pop) begin
        r_addr  <= w_head.addr;
        r_data  <= w_head.data;
        r_sel   <= w_head.sel;
        r_rem   <= w_head.count;
        r_hold  <= HW'(1);
        r_state <= S_WRITE;
      end else if (r_state == S_WRITE) begin
        if (w_done || w_abort) begin
          r_state <= S_GAP;
          if (w_abort) r_rem <= '0;
        end else r_hold <= r_hold + 1'b1;
      end else if (r_state == S_GAP) begin
        if (|r_rem) begin
          r_rem   <= r_rem - 1'b1;
          r_addr  <= r_addr + 27'(ADDR_STEP);
          r_hold  <= HW'(1);
          r_state <= S_WRITE;
        end else r_state <= S_IDLE;
      end
    end
  end
  assign wb_we_o      = r_state == S_WRITE;
  assign wb_adr_o     = wb_we_o ? r_addr : '0;
  assign wb_dat_o     = wb_we_o ? r_data : '0;
  assign wb_sel_o     = wb_we_o ? r_sel : '0;
  assign o_push_ready = !w_full;
  assign o_busy       = !w_empty || r_state != S_IDLE;
  assign o_timeout    = r_timeout;
endmodule

// File: tb/tb_gpu_wb_write_queue.sv
// tb_gpu_wb_write_queue: directed and random checks of the write queue against a queue-of-expected-writes model.
module tb_gpu_wb_write_queue;
  logic        clk_100MHz = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_push_valid = 1'b0;
  logic        o_push_ready;
  logic [26:0] i_push_addr = '0;
  logic [31:0] i_push_data = '0;
  logic [3:0]  i_push_sel = '0;
  logic [7:0]  i_push_count = '0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [26:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_ack_i = 1'b0;
  logic        o_busy;
  logic [4:0]  o_level;
  logic        o_timeout;
  logic        i_clr_timeout = 1'b0;

  gpu_wb_write_queue dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n),
    .i_push_valid(i_push_valid), .o_push_ready(o_push_ready),
    .i_push_addr(i_push_addr), .i_push_data(i_push_data),
    .i_push_sel(i_push_sel), .i_push_count(i_push_count),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .o_busy(o_busy), .o_level(o_level),
    .o_timeout(o_timeout), .i_clr_timeout(i_clr_timeout)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic [26:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          len;
  } wr_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          ack_mode = 0;
  int          cur_len = 0;
  bit          next_abort = 0;
  int          hold_len = 0;
  int          last_len = 0;
  int          n_writes = 0;
  int          act = 0;
  int          base;
  bit          was_we = 0;
  logic [26:0] h_adr;
  logic [31:0] h_dat;
  logic [3:0]  h_sel;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Each accepted command expands into count+1 writes at consecutive addresses; an aborted one into a single held write.
  task automatic model_push();
    if (next_abort) begin
      exp_q.push_back('{i_push_addr, i_push_data, i_push_sel, 255});
      next_abort = 0;
    end else
      for (int i = 0; i <= int'(i_push_count); i++)
        exp_q.push_back('{i_push_addr + 27'(i), i_push_data, i_push_sel, cur_len});
  endtask

  task automatic finish_write();
    wr_t e;
    n_writes++;
    last_len = hold_len;
    chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("write_word", 64'({h_adr, h_dat, h_sel}), 64'({e.addr, e.data, e.sel}));
      if (e.len != 0) chk("write_len", 64'(hold_len), 64'(e.len));
      else chk("write_len_min", 64'(hold_len >= 2), 64'd1);
    end
  endtask

  task automatic tick();
    logic acc, rst_b;
    acc = i_push_valid && o_push_ready && reset_n;
    rst_b = !reset_n;
    @(posedge clk_100MHz); #1;
    if (acc) model_push();
    if (rst_b) begin
      exp_q.delete();
      hold_len = 0;
    end
    if (wb_we_o) begin
      if (hold_len != 0) chk("bus_stable", 64'({wb_adr_o, wb_dat_o, wb_sel_o}), 64'({h_adr, h_dat, h_sel}));
      else {h_adr, h_dat, h_sel} = {wb_adr_o, wb_dat_o, wb_sel_o};
      hold_len++;
    end else begin
      chk("bus_idle_zero", 64'({wb_adr_o, wb_dat_o, wb_sel_o}), 64'd0);
      if (hold_len != 0) finish_write();
      hold_len = 0;
    end
    if (wb_we_o || was_we) act++;
    was_we = wb_we_o;
    wb_ack_i = ack_mode == 0 ? 1'b0 : ack_mode == 1 ? !wb_ack_i :
               ack_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic set_push(input logic v, input logic [26:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [7:0] c);
    i_push_valid = v;
    i_push_addr = a;
    i_push_data = d;
    i_push_sel = s;
    i_push_count = c;
  endtask

  task automatic wait_idle(input int max, input string tag);
    for (int i = 0; i < max && o_busy; i++) tick();
    chk(tag, 64'(o_busy), 64'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_we", 64'(wb_we_o), 64'd0);
    chk("rst_bus", 64'({wb_adr_o, wb_dat_o, wb_sel_o}), 64'd0);
    chk("rst_ready", 64'(o_push_ready), 64'd1);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single write against the alternating-ack slave.
    ack_mode = 1;
    set_push(1, 27'h1004, 32'hDEADBEEF, 4'hF, 8'd0);
    tick();
    set_push(0, 0, 0, 0, 0);
    chk("single_we_after_push", 64'(wb_we_o), 64'd0);
    chk("single_level", 64'(o_level), 64'd1);
    tick();
    chk("single_we_rise", 64'(wb_we_o), 64'd1);
    chk("single_adr", 64'(wb_adr_o), 64'h1004);
    chk("single_level_popped", 64'(o_level), 64'd0);
    for (int i = 0; i < 10 && wb_we_o; i++) tick();
    chk("single_drop", 64'(wb_we_o), 64'd0);
    chk("single_len", 64'(last_len == 2 || last_len == 3), 64'd1);
    chk("single_gap_busy", 64'(o_busy), 64'd1);
    tick();
    chk("single_busy_fall", 64'(o_busy), 64'd0);

    // Fill of four words with the slave always acking.
    ack_mode = 3;
    cur_len = 2;
    base = n_writes;
    act = 0;
    set_push(1, 27'h2000, 32'h0, 4'hF, 8'd3);
    tick();
    set_push(0, 0, 0, 0, 0);
    wait_idle(60, "fill_idle");
    chk("fill_writes", 64'(n_writes - base), 64'd4);
    chk("fill_activity", 64'(act), 64'd12);
    cur_len = 0;

    // Bus stalled by a command that times out while the FIFO fills behind it.
    ack_mode = 0;
    wb_ack_i = 1'b0;
    i_clr_timeout = 1'b1;
    next_abort = 1;
    set_push(1, 27'h3000, 32'hAA, 4'h3, 8'd2);
    tick();
    for (int i = 1; i <= 17; i++) begin
      set_push(1, 27'h100 + 27'(i), 32'(i), 4'hF, 8'd0);
      if (i == 17) begin
        chk("full_ready", 64'(o_push_ready), 64'd0);
        chk("full_level", 64'(o_level), 64'd16);
      end
      tick();
    end
    set_push(0, 0, 0, 0, 0);
    chk("full_level_after17", 64'(o_level), 64'd16);
    chk("full_busy", 64'(o_busy), 64'd1);
    for (int i = 0; i < 400 && !o_timeout; i++) tick();
    chk("timeout_set_wins", 64'(o_timeout), 64'd1);
    i_clr_timeout = 1'b0;
    ack_mode = 1;
    tick();
    tick();
    chk("timeout_sticky", 64'(o_timeout), 64'd1);
    i_clr_timeout = 1'b1;
    tick();
    i_clr_timeout = 1'b0;
    chk("timeout_cleared", 64'(o_timeout), 64'd0);
    wait_idle(400, "after_timeout_idle");
    chk("after_timeout_drained", 64'(exp_q.size()), 64'd0);

    // Push while the head is being popped keeps the level steady and the order intact.
    ack_mode = 3;
    set_push(1, 27'h50, 32'd1, 4'h1, 8'd0);
    tick();
    chk("pp_level1", 64'(o_level), 64'd1);
    set_push(1, 27'h51, 32'd2, 4'h2, 8'd0);
    tick();
    chk("pp_level_same", 64'(o_level), 64'd1);
    set_push(1, 27'h52, 32'd3, 4'h4, 8'd0);
    tick();
    set_push(0, 0, 0, 0, 0);
    wait_idle(60, "pp_idle");
    chk("pp_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a held write.
    ack_mode = 0;
    wb_ack_i = 1'b0;
    set_push(1, 27'h60, 32'h1234, 4'hF, 8'd5);
    tick();
    set_push(1, 27'h70, 32'h5678, 4'hF, 8'd0);
    tick();
    set_push(0, 0, 0, 0, 0);
    chk("rstmid_we_high", 64'(wb_we_o), 64'd1);
    reset_n = 1'b0;
    tick();
    chk("rstmid_we", 64'(wb_we_o), 64'd0);
    chk("rstmid_level", 64'(o_level), 64'd0);
    chk("rstmid_ready", 64'(o_push_ready), 64'd1);
    chk("rstmid_busy", 64'(o_busy), 64'd0);
    reset_n = 1'b1;
    ack_mode = 3;
    base = n_writes;
    for (int i = 0; i < 10; i++) tick();
    chk("rstmid_no_writes", 64'(n_writes - base), 64'd0);
    chk("rstmid_still_idle", 64'(wb_we_o), 64'd0);

    // Random traffic against a random-ack slave, starting with an address wrap.
    ack_mode = 2;
    set_push(1, 27'h7FFFFFE, 32'h55, 4'hA, 8'd3);
    tick();
    for (int i = 0; i < 60; i++) begin
      set_push(1'($urandom_range(0, 1)), 27'($urandom), $urandom, 4'($urandom),
               8'($urandom_range(0, 3)));
      tick();
    end
    set_push(0, 0, 0, 0, 0);
    wait_idle(3000, "rand_idle");
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
